// File: rtl/scalar_regfile_sb.sv
// Scalar register bank with NUM_RD_PORTS registered read ports, one write port
// and a per-register busy scoreboard driven by issue reserves and write-backs.

module scalar_regfile_sb_rdport #(
    parameter int SCALAR_REG_WIDTH = 64,
    parameter int AW               = 5,
    parameter int ZERO_REG         = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_en,
    input  logic [AW-1:0]               rd_addr,
    input  logic [SCALAR_REG_WIDTH-1:0] arr_data,
    input  logic                        arr_busy,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [SCALAR_REG_WIDTH-1:0] wr_data,
    input  logic                        wr_clr_busy,
    output logic                        rd_valid,
    output logic [SCALAR_REG_WIDTH-1:0] rd_data,
    output logic                        rd_busy
);
    typedef struct packed {
        logic                        valid;
        logic                        busy;
        logic [SCALAR_REG_WIDTH-1:0] data;
    } rd_rsp_t;

    rd_rsp_t rsp_q;
    logic                        wr_hit;
    logic                        is_zero;
    logic [SCALAR_REG_WIDTH-1:0] data_nxt;
    logic                        busy_nxt;

    always_comb begin
        wr_hit   = wr_en && (wr_addr == rd_addr);
        is_zero  = (ZERO_REG != 0) && (rd_addr == '0);
        data_nxt = arr_data;
        if (is_zero)
            data_nxt = '0;
        else if (wr_hit)
            data_nxt = wr_data;
        // A same-cycle reserve is deliberately ignored so an instruction can
        // read its own destination register as a source.
        busy_nxt = arr_busy && !(wr_hit && wr_clr_busy);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_q <= '0;
        end else begin
            rsp_q.valid <= rd_en;
            if (rd_en) begin
                rsp_q.data <= data_nxt;
                rsp_q.busy <= busy_nxt;
            end
        end
    end

    assign rd_valid = rsp_q.valid;
    assign rd_data  = rsp_q.data;
    assign rd_busy  = rsp_q.busy;
endmodule

module scalar_regfile_sb #(
    parameter int SCALAR_REG_WIDTH = 64,
    parameter int SCALAR_REG_DEPTH = 32,
    parameter int NUM_RD_PORTS     = 3,
    parameter int ZERO_REG         = 0,
    localparam int AW = $clog2(SCALAR_REG_DEPTH),
    localparam int CW = $clog2(SCALAR_REG_DEPTH + 1)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_RD_PORTS-1:0]                  rd_en,
    input  logic [NUM_RD_PORTS*AW-1:0]               rd_addr,
    output logic [NUM_RD_PORTS-1:0]                  rd_valid,
    output logic [NUM_RD_PORTS*SCALAR_REG_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]                  rd_busy,
    input  logic                                     rsv_valid,
    input  logic [AW-1:0]                            rsv_addr,
    output logic                                     rsv_ready,
    input  logic                                     wr_en,
    input  logic [AW-1:0]                            wr_addr,
    input  logic [SCALAR_REG_WIDTH-1:0]              wr_data,
    input  logic                                     wr_clr_busy,
    output logic [SCALAR_REG_DEPTH-1:0]              busy_vec,
    output logic [CW-1:0]                            pending_cnt,
    output logic                                     err_wb_unreserved,
    input  logic                                     err_clr
);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [SCALAR_REG_WIDTH-1:0] regs [SCALAR_REG_DEPTH];
    logic [SCALAR_REG_DEPTH-1:0] busy_q, busy_nxt;
    logic [CW-1:0]               pending_q;
    logic                        err_q;

    logic wr_zero, rsv_zero, clr_req, rsv_set, cnt_inc, cnt_dec, err_set;

    always_comb begin
        wr_zero   = HAS_ZERO && (wr_addr == '0);
        rsv_zero  = HAS_ZERO && (rsv_addr == '0);
        clr_req   = wr_en && wr_clr_busy && !wr_zero;
        rsv_ready = rsv_zero || !busy_q[rsv_addr] ||
                    (wr_en && wr_clr_busy && (wr_addr == rsv_addr));
        rsv_set   = rsv_valid && rsv_ready && !rsv_zero;
        err_set   = clr_req && !busy_q[wr_addr];

        // Clear is applied before set so a same-address reserve wins.
        busy_nxt = busy_q;
        if (clr_req)
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_set)
            busy_nxt[rsv_addr] = 1'b1;

        cnt_dec = clr_req && busy_q[wr_addr];
        cnt_inc = rsv_set &&
                  !(busy_q[rsv_addr] && !(clr_req && (wr_addr == rsv_addr)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SCALAR_REG_DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_en && !wr_zero) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_nxt;
            pending_q <= pending_q + CW'(cnt_inc) - CW'(cnt_dec);
            if (err_clr)
                err_q <= 1'b0;
            else if (err_set)
                err_q <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        scalar_regfile_sb_rdport #(
            .SCALAR_REG_WIDTH(SCALAR_REG_WIDTH),
            .AW              (AW),
            .ZERO_REG        (ZERO_REG)
        ) u_rd (
            .clk        (clk),
            .reset      (reset),
            .rd_en      (rd_en[p]),
            .rd_addr    (rd_addr[p*AW +: AW]),
            .arr_data   (regs[rd_addr[p*AW +: AW]]),
            .arr_busy   (busy_q[rd_addr[p*AW +: AW]]),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .wr_clr_busy(wr_clr_busy),
            .rd_valid   (rd_valid[p]),
            .rd_data    (rd_data[p*SCALAR_REG_WIDTH +: SCALAR_REG_WIDTH]),
            .rd_busy    (rd_busy[p])
        );
    end

    assign busy_vec          = busy_q;
    assign pending_cnt       = pending_q;
    assign err_wb_unreserved = err_q;
endmodule

// File: tb/tb_scalar_regfile_sb.sv
// Drives a ZERO_REG=0 and a ZERO_REG=1 bank with identical stimulus and checks
// both against an array-based reference model of the register/scoreboard rules.

module tb_scalar_regfile_sb;
    localparam int W = 64, D = 32, NP = 3, AW = 5, CW = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NP-1:0]    rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic             rsv_valid;
    logic [AW-1:0]    rsv_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic             wr_clr_busy;
    logic             err_clr;

    logic [1:0][NP-1:0]   rdv, rdb;
    logic [1:0][NP*W-1:0] rdd;
    logic [1:0]           rdy, err;
    logic [1:0][D-1:0]    bvec;
    logic [1:0][CW-1:0]   pcnt;

    scalar_regfile_sb #(.SCALAR_REG_WIDTH(W), .SCALAR_REG_DEPTH(D), .NUM_RD_PORTS(NP), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rdv[0]), .rd_data(rdd[0]), .rd_busy(rdb[0]),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rdy[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr_busy(wr_clr_busy),
        .busy_vec(bvec[0]), .pending_cnt(pcnt[0]), .err_wb_unreserved(err[0]), .err_clr(err_clr)
    );

    scalar_regfile_sb #(.SCALAR_REG_WIDTH(W), .SCALAR_REG_DEPTH(D), .NUM_RD_PORTS(NP), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rdv[1]), .rd_data(rdd[1]), .rd_busy(rdb[1]),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rdy[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr_busy(wr_clr_busy),
        .busy_vec(bvec[1]), .pending_cnt(pcnt[1]), .err_wb_unreserved(err[1]), .err_clr(err_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model; index 1 is the zero-register instance.
    logic [W-1:0] m_reg  [2][D];
    bit           m_busy [2][D];
    bit           m_err  [2];
    logic [W-1:0] m_rdd  [2][NP];
    bit           m_rdv  [2][NP];
    bit           m_rdb  [2][NP];

    task automatic chk(string tag, int z, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, z, obs, exp);
        end
    endtask

    function automatic int popc(int z);
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m_busy[z][i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < D; i++) begin m_reg[z][i] = '0; m_busy[z][i] = 0; end
            for (int p = 0; p < NP; p++) begin m_rdd[z][p] = '0; m_rdv[z][p] = 0; m_rdb[z][p] = 0; end
            m_err[z] = 0;
        end
    endtask

    function automatic bit model_ready(int z);
        if (z == 1 && rsv_addr == 0) return 1;
        if (!m_busy[z][rsv_addr]) return 1;
        return wr_en && wr_clr_busy && (wr_addr == rsv_addr);
    endfunction

    task automatic model_cycle(int z, bit ready);
        bit wz;
        wz = (z == 1) && (wr_addr == 0);
        for (int p = 0; p < NP; p++) begin
            int a;
            a = int'(rd_addr[p*AW +: AW]);
            m_rdv[z][p] = rd_en[p];
            if (rd_en[p]) begin
                if (z == 1 && a == 0)             m_rdd[z][p] = '0;
                else if (wr_en && wr_addr == a)   m_rdd[z][p] = wr_data;
                else                              m_rdd[z][p] = m_reg[z][a];
                m_rdb[z][p] = m_busy[z][a] && !(wr_en && wr_clr_busy && wr_addr == a);
            end
        end
        if (err_clr)
            m_err[z] = 0;
        else if (wr_en && wr_clr_busy && !wz && !m_busy[z][wr_addr])
            m_err[z] = 1;
        if (wr_en && !wz) m_reg[z][wr_addr] = wr_data;
        if (wr_en && wr_clr_busy && !wz) m_busy[z][wr_addr] = 0;
        if (rsv_valid && ready && !(z == 1 && rsv_addr == 0)) m_busy[z][rsv_addr] = 1;
    endtask

    task automatic check_outputs();
        for (int z = 0; z < 2; z++) begin
            logic [D-1:0] eb;
            for (int i = 0; i < D; i++) eb[i] = m_busy[z][i];
            for (int p = 0; p < NP; p++) begin
                chk("rd_valid", z, rdv[z][p], m_rdv[z][p]);
                chk("rd_data",  z, rdd[z][p*W +: W], m_rdd[z][p]);
                chk("rd_busy",  z, rdb[z][p], m_rdb[z][p]);
            end
            chk("busy_vec", z, bvec[z], eb);
            chk("pending_cnt", z, pcnt[z], popc(z));
            chk("err", z, err[z], m_err[z]);
        end
    endtask

    task automatic check_zero(string tag);
        for (int z = 0; z < 2; z++) begin
            chk({tag, "_rdv"}, z, rdv[z], 0);
            for (int p = 0; p < NP; p++) chk({tag, "_rdd"}, z, rdd[z][p*W +: W], 0);
            chk({tag, "_rdb"}, z, rdb[z], 0);
            chk({tag, "_busy"}, z, bvec[z], 0);
            chk({tag, "_cnt"}, z, pcnt[z], 0);
            chk({tag, "_err"}, z, err[z], 0);
        end
    endtask

    // Called at posedge+1 with inputs set; checks rsv_ready, clocks, checks outputs.
    task automatic step();
        bit r [2];
        #1;
        for (int z = 0; z < 2; z++) begin
            r[z] = model_ready(z);
            chk("rsv_ready", z, rdy[z], r[z]);
        end
        for (int z = 0; z < 2; z++) model_cycle(z, r[z]);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; rsv_valid = 0; rsv_addr = '0;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_clr_busy = 0; err_clr = 0;
    endtask

    task automatic set_rd(int p, int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        #2;
        check_zero("reset_init");
        @(posedge clk); #1;
        reset = 1'b0;

        // Bypass: write r5 while all ports read r5
        idle();
        wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF_0000_0001;
        for (int p = 0; p < NP; p++) set_rd(p, 5);
        step();
        for (int z = 0; z < 2; z++) begin
            chk("bypass_valid", z, rdv[z], 3'b111);
            for (int p = 0; p < NP; p++) chk("bypass_data", z, rdd[z][p*W +: W], 64'hDEAD_BEEF_0000_0001);
        end

        // Scoreboard handshake on r7
        idle(); rsv_valid = 1; rsv_addr = 7;
        step();
        for (int z = 0; z < 2; z++) begin
            chk("rsv7_busy", z, bvec[z][7], 1);
            chk("rsv7_cnt", z, pcnt[z], 1);
        end
        #1;
        for (int z = 0; z < 2; z++) chk("rsv7_again_ready", z, rdy[z], 0);
        step();
        for (int z = 0; z < 2; z++) chk("rsv7_again_cnt", z, pcnt[z], 1);
        wr_en = 1; wr_addr = 7; wr_clr_busy = 1; wr_data = 64'h77;
        #1;
        for (int z = 0; z < 2; z++) chk("clr_rsv7_ready", z, rdy[z], 1);
        step();
        for (int z = 0; z < 2; z++) begin
            chk("clr_rsv7_busy", z, bvec[z][7], 1);
            chk("clr_rsv7_cnt", z, pcnt[z], 1);
        end
        idle(); wr_en = 1; wr_addr = 7; wr_clr_busy = 1;
        step();

        // Read-before-reserve on r3
        idle(); set_rd(0, 3); rsv_valid = 1; rsv_addr = 3;
        step();
        for (int z = 0; z < 2; z++) chk("rbr_busy0", z, rdb[z][0], 0);
        idle(); set_rd(0, 3);
        step();
        for (int z = 0; z < 2; z++) chk("rbr_busy1", z, rdb[z][0], 1);
        idle(); wr_en = 1; wr_addr = 3; wr_clr_busy = 1;
        step();

        // Zero register
        idle(); wr_en = 1; wr_addr = 0; wr_data = 64'hFF;
        step();
        idle(); for (int p = 0; p < NP; p++) set_rd(p, 0);
        step();
        chk("zero_read", 1, rdd[1][0 +: W], 0);
        chk("nonzero_read", 0, rdd[0][0 +: W], 64'hFF);
        idle(); rsv_valid = 1; rsv_addr = 0;
        #1;
        chk("zero_rsv_ready", 1, rdy[1], 1);
        step();
        chk("zero_rsv_busy", 1, bvec[1], 0);
        idle(); wr_en = 1; wr_addr = 0; wr_clr_busy = 1;
        step();
        chk("zero_wb_err", 1, err[1], 0);

        // Error on unreserved write-back, then err_clr
        idle(); wr_en = 1; wr_addr = 9; wr_clr_busy = 1; wr_data = 64'h1234_5678_9ABC_DEF0;
        step();
        for (int z = 0; z < 2; z++) chk("err_set", z, err[z], 1);
        idle(); set_rd(1, 9);
        step();
        for (int z = 0; z < 2; z++) chk("err_r9_data", z, rdd[z][W +: W], 64'h1234_5678_9ABC_DEF0);
        idle(); err_clr = 1;
        step();
        for (int z = 0; z < 2; z++) chk("err_clr", z, err[z], 0);

        // Fill and drain the scoreboard
        for (int a = 0; a < D; a++) begin idle(); rsv_valid = 1; rsv_addr = AW'(a); step(); end
        chk("full_cnt", 0, pcnt[0], 32);
        chk("full_cnt", 1, pcnt[1], 31);
        for (int a = 0; a < D; a++) begin idle(); wr_en = 1; wr_clr_busy = 1; wr_addr = AW'(a); step(); end
        for (int z = 0; z < 2; z++) begin
            chk("drain_cnt", z, pcnt[z], 0);
            chk("drain_err", z, err[z], 0);
        end

        // Random traffic on a narrow address range, with a mid-run async reset
        for (int i = 0; i < 400; i++) begin
            rd_en = NP'($urandom);
            for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            rsv_valid   = 1'($urandom);
            rsv_addr    = AW'($urandom_range(0, 7));
            wr_en       = 1'($urandom);
            wr_addr     = AW'($urandom_range(0, 7));
            wr_data     = {$urandom, $urandom};
            wr_clr_busy = 1'($urandom);
            err_clr     = ($urandom_range(0, 15) == 0);
            if (i == 200) begin
                #3;
                reset = 1'b1;
                #1;
                check_zero("reset_mid");
                model_reset();
                @(posedge clk); #1;
                reset = 1'b0;
                for (int a = 0; a < 8; a++) begin
                    idle();
                    for (int p = 0; p < NP; p++) set_rd(p, a);
                    step();
                    for (int z = 0; z < 2; z++) chk("post_reset_data", z, rdd[z], 0);
                end
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scalar_regfile_sb.md
# scalar_regfile_sb

Parametrised scalar register bank with a built-in scoreboard, replacing the fixed 32x64 single-read-port bank. It provides NUM_RD_PORTS registered read ports with write-through bypass and one write port. A per-register busy bit is set by a reserve handshake from issue and cleared by write-back, so issue logic can stall on pending results. One instance per register class: integer with ZERO_REG=1, floating point with ZERO_REG=0.

## Interface
- SCALAR_REG_WIDTH, 64, data width in bits
- SCALAR_REG_DEPTH, 32, number of registers (power of two, ≥2); AW = $clog2(SCALAR_REG_DEPTH)
- NUM_RD_PORTS, 3, number of read ports (1..4)
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes, never becomes busy
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- rd_en  in  NUM_RD_PORTS  per-port read request
- rd_addr  in  NUM_RD_PORTS*AW  per-port address; port p at [p*AW +: AW]
- rd_valid  out  NUM_RD_PORTS  registered; high one cycle after a sampled rd_en
- rd_data  out  NUM_RD_PORTS*SCALAR_REG_WIDTH  registered read data; port p at [p*W +: W]
- rd_busy  out  NUM_RD_PORTS  registered busy status of the addressed register
- rsv_valid  in  1  reserve request from issue
- rsv_addr  in  AW  destination register to reserve
- rsv_ready  out  1  combinational; the reserve is accepted when rsv_valid && rsv_ready
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  SCALAR_REG_WIDTH  write data
- wr_clr_busy  in  1  write is a write-back that clears the busy bit; qualified by wr_en
- busy_vec  out  SCALAR_REG_DEPTH  current busy bits
- pending_cnt  out  $clog2(SCALAR_REG_DEPTH+1)  number of set busy bits
- err_wb_unreserved  out  1  sticky; set by a clearing write-back to a non-busy register
- err_clr  in  1  synchronous clear of the sticky error

## Operation
- Reset: all registers, busy_vec, pending_cnt, rd_valid, rd_data, rd_busy and err_wb_unreserved are 0. A reset mid-operation discards all reservations and any in-flight read results.
- Write: when wr_en is high, reg[wr_addr] <= wr_data at the clock edge. If ZERO_REG=1 and wr_addr=0, the data is dropped.
- Read port p, when rd_en[p] is sampled high:
  - rd_data[p] <= reg[rd_addr[p]], or wr_data if wr_en is high and wr_addr == rd_addr[p] in the same cycle (bypass).
  - With ZERO_REG=1 and address 0, rd_data[p] <= 0.
  - rd_busy[p] <= busy[rd_addr[p]] & ~(clearing write-back to that address in the same cycle).
  - A same-cycle reserve does not affect rd_busy. This lets an instruction read its own destination as a source.
  - When rd_en[p] is low, rd_valid[p] <= 0 and rd_data/rd_busy hold their previous values.
- rsv_ready = !busy[rsv_addr] || (wr_en && wr_clr_busy && wr_addr == rsv_addr). With ZERO_REG=1 and rsv_addr=0, rsv_ready is 1.
- An accepted reserve sets busy[rsv_addr] (skipped for zero register). A reserve that is not ready has no effect; the requester holds rsv_valid and rsv_addr.
- A clearing write-back (wr_en && wr_clr_busy):
  - If the target is busy, it clears busy[wr_addr].
  - If the target is not busy, the data is still written and err_wb_unreserved is set.
  - The zero register never raises the error.
- A plain write (wr_clr_busy=0) never touches busy bits.
- Reserve and clear to the same address in the same cycle: the busy bit ends at 1, the reserve is accepted, and pending_cnt is unchanged.
- pending_cnt: +1 on an accepted reserve that sets a bit, −1 on a clear of a set bit, net 0 for both together. It always equals popcount(busy_vec) and never wraps.
- Errors: err_clr has priority over a same-cycle set, so err_clr wins.

## Timing
- Read latency: 1 cycle, fully pipelined. Any port may read every cycle, and all ports may use the same address.
- Write to read visibility: 0 cycles through the bypass. A read issued the cycle after a write sees the array value.
- rsv_ready is combinational from rsv_addr, busy_vec and the write-back inputs; there is no path from rsv_valid to rsv_ready.
- busy_vec, pending_cnt and err_wb_unreserved update at the clock edge that performs the reserve or clear.

## Test plan
- Reset with stimulus active: assert reset asynchronously mid-traffic. Required: every output goes to 0 immediately, and all reads after release return 0.
- Bypass: write reg5=0xDEAD_BEEF_0000_0001 while all 3 ports read addr 5 in the same cycle. Required: the next cycle all rd_data = 0xDEAD_BEEF_0000_0001 with rd_valid=3'b111.
- Scoreboard handshake:
  - Reserve r7. Required: busy_vec[7]=1, pending_cnt=1.
  - Reserve r7 again. Required: rsv_ready=0 and no state change.
  - Clearing write-back to r7 with a same-cycle reserve of r7. Required: rsv_ready=1, busy stays 1, pending_cnt=1.
- Read-before-reserve: read r3 and reserve r3 in the same cycle. Required: rd_busy=0 next cycle.
  - Then read r3 again. Required: rd_busy=1.
- Zero register (ZERO_REG=1): write r0=0xFF. Required: reads of r0 return 0.
  - Reserve r0. Required: accepted with busy_vec unchanged.
  - Clearing write-back to r0. Required: no error.
- Error and full: clearing write-back to unreserved r9. Required: err_wb_unreserved=1 and r9 written.
  - Assert err_clr. Required: error is 0 next cycle.
  - Reserve all 32 registers. Required: pending_cnt=32.
  - Clear all 32 registers. Required: pending_cnt=0.
